graphic_stream_arbiter: RTL and testbench
=========================================

// Module: graphic_stream_arbiter
// PURPOSE
//  Frame-granular arbiter sharing one AXI-Stream video sink between two graphic_generator pixel sources.
//  RGB565, tuser=SOF, tlast=EOL. Sits between the generators and the display/output stream.
//  Switches source only at frame boundaries. Fixed-select or per-frame round-robin policy.
// PARAMETERS
//  DATA_WIDTH  16   pixel width (tdata)
//  H_RES       640  pixels per line
//  V_RES       480  lines per frame
//  CNT_W       12   width of pixel/line counters; must satisfy 2^CNT_W > max(H_RES,V_RES)
// PORTS
//  hclk        in   1           clock
//  hreset      in   1           synchronous reset, active-high
//  ce          in   1           clock enable; when 0 all state frozen and all tready=0, m_tvalid=0
//  mode        in   1           0=fixed (fixed_sel only), 1=round-robin per frame; sampled in IDLE
//  fixed_sel   in   1           source used in fixed mode
//  s0_tdata    in   DATA_WIDTH  source 0 pixel
//  s0_tlast    in   1           source 0 EOL
//  s0_tuser    in   1           source 0 SOF
//  s0_tvalid   in   1           source 0 valid
//  s0_tready   out  1           source 0 ready
//  s1_*        -    -           source 1, same set as s0_*
//  m_tdata     out  DATA_WIDTH  sink pixel
//  m_tlast     out  1           sink EOL
//  m_tuser     out  1           sink SOF
//  m_tvalid    out  1           sink valid
//  m_tready    in   1           sink ready
//  active_src  out  1           granted source (valid while busy=1)
//  busy        out  1           1 in PASS state
//  frame_done  out  1           one-cycle pulse after last beat of frame handshakes
//  err         out  1           sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE, active_src=0, last_grant=1 (so source 0 wins first RR tie), busy=0, frame_done=0, err=0,
//    line/pixel counters=0; m_tvalid=0, s0/s1_tready=0 during reset cycle.
//  - Handshake = tvalid&&tready&&ce. Master outputs never depend on m_tready except via pass-through.
//  - IDLE: source n eligible if sn_tvalid&&sn_tuser (and n==fixed_sel when mode=0).
//    Non-SOF beats (tvalid&&!tuser) are discarded: sn_tready=1 for them. SOF beats held: tready=0.
//    Ungranted sources in fixed mode: SOF held indefinitely, non-SOF beats discarded.
//    Grant: one eligible -> it; both eligible (RR) -> !last_grant. Registered: next cycle state=PASS,
//    active_src=grant, last_grant=grant, counters cleared. m_tvalid=0 in IDLE.
//  - PASS: zero-latency combinational mux: m_* = s[active_src]_*, s[active_src]_tready=m_tready,
//    other source tready=0. SOF beat passes as first beat of frame.
//    Line counter increments on each tlast handshake. On tlast handshake with line==V_RES-1:
//    next state IDLE, frame_done=1 for exactly one cycle, busy=0.
//  - Source with tvalid low mid-frame: sink simply sees m_tvalid=0; no timeout, grant retained.
//  - mode/fixed_sel changes in PASS take effect at next IDLE only.
//  - Reset mid-frame: immediate abort to reset values; sink sees truncated frame (no tlast fix-up).
//  - Counter wrap impossible by CNT_W rule; pixel counter resets on each tlast handshake.
// CONFIGURATION
//  Macro GSA_STREAM_CHECK_EN:
//   defined -> pixel counter checks each PASS beat: tlast at pixel!=H_RES-1, missing tlast at pixel==H_RES-1,
//     or tuser=1 on any beat but first of frame sets err (sticky until hreset). Stream still forwarded unchanged.
//   undefined -> no pixel counter, err tied 0; line counting/frame_done unchanged.
// TESTING (run with H_RES=4, V_RES=3 and macro both defined and undefined)
//  1 reset, mode=0 fixed_sel=1, s1 sends 12-beat frame, m_tready=1 -> 12 beats on m_*, frame_done pulse 1 cycle after beat 12, s0_tready=0 throughout.
//  2 mode=1, s0 and s1 both present SOF same cycle -> s0 frame first, then s1, then s0 (alternation over 3 frames).
//  3 in IDLE s0 presents 5 non-SOF beats then SOF -> 5 beats accepted, none on m_*, grant 1 cycle after SOF seen, SOF is first m_ beat with m_tuser=1.
//  4 m_tready toggles 1/0 every cycle during frame -> beats in order, no loss/duplication, s0_tready==m_tready while granted.
//  5 hreset asserted after beat 6 of frame -> next cycle m_tvalid=0, busy=0, state IDLE; fresh SOF re-granted normally.
//  6 macro defined: tlast on beat 3 of a line -> err=1 and stays 1; macro undefined: err=0.

Source files
------------

// File: rtl/graphic_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : graphic_stream_arbiter_if
// Brief   : AXI-Stream video bundle (RGB565, tuser=SOF, tlast=EOL).
// Revision: 1.0 - initial release
// ============================================================================
interface graphic_stream_arbiter_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tuser;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tlast, tuser, tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/graphic_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : graphic_stream_arbiter
// Brief   : Frame-granular two-source AXI-Stream video arbiter; fixed or
//           per-frame round-robin. GSA_STREAM_CHECK_EN adds the err checker.
// Revision: 1.0 - initial release
// ============================================================================
module graphic_stream_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int CNT_W      = 12
) (
  input  var logic                 hclk,
  input  var logic                 hreset,
  input  var logic                 ce,
  input  var logic                 mode,
  input  var logic                 fixed_sel,
  graphic_stream_arbiter_if.slave  s0,
  graphic_stream_arbiter_if.slave  s1,
  graphic_stream_arbiter_if.master m,
  output logic                     active_src,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     err
);

  localparam int MAX_RES = (H_RES > V_RES) ? H_RES : V_RES;

  if (MAX_RES >= (1 << CNT_W)) begin : g_cnt_w_check
    $error("CNT_W too small for H_RES/V_RES");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             active_q, active_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] line_q, line_d;
  logic             frame_done_q, frame_done_d;

  logic                  run;
  logic                  elig0, elig1, grant, start;
  logic [DATA_WIDTH-1:0] sel_tdata;
  logic                  sel_tlast, sel_tuser, sel_tvalid;
  logic                  hs, eol, last_line;

  assign run   = ce && !hreset;
  assign elig0 = s0.tvalid && s0.tuser && (mode || !fixed_sel);
  assign elig1 = s1.tvalid && s1.tuser && (mode || fixed_sel);
  // Tie between two eligible sources goes to whoever did not win last time.
  assign grant = (elig0 && elig1) ? !last_grant_q : elig1;
  assign start = run && (state_q == IDLE) && (elig0 || elig1);

  assign sel_tdata  = active_q ? s1.tdata  : s0.tdata;
  assign sel_tlast  = active_q ? s1.tlast  : s0.tlast;
  assign sel_tuser  = active_q ? s1.tuser  : s0.tuser;
  assign sel_tvalid = active_q ? s1.tvalid : s0.tvalid;

  assign hs        = run && (state_q == PASS) && sel_tvalid && m.tready;
  assign eol       = hs && sel_tlast;
  assign last_line = (line_q == CNT_W'(V_RES - 1));

  always_comb begin
    m.tdata   = sel_tdata;
    m.tlast   = sel_tlast;
    m.tuser   = sel_tuser;
    m.tvalid  = 1'b0;
    s0.tready = 1'b0;
    s1.tready = 1'b0;
    if (run) begin
      if (state_q == PASS) begin
        m.tvalid = sel_tvalid;
        if (active_q) s1.tready = m.tready;
        else          s0.tready = m.tready;
      end else begin
        // Idle: flush stray mid-frame beats, hold SOF until granted.
        s0.tready = s0.tvalid && !s0.tuser;
        s1.tready = s1.tvalid && !s1.tuser;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    last_grant_d = last_grant_q;
    line_d       = line_q;
    frame_done_d = 1'b0;
    if (run) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d      = PASS;
            active_d     = grant;
            last_grant_d = grant;
            line_d       = '0;
          end
        end
        PASS: begin
          if (eol) begin
            if (last_line) begin
              state_d      = IDLE;
              line_d       = '0;
              frame_done_d = 1'b1;
            end else begin
              line_d = line_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= IDLE;
      active_q     <= 1'b0;
      last_grant_q <= 1'b1;
      line_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      last_grant_q <= last_grant_d;
      line_q       <= line_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign active_src = active_q;
  assign busy       = (state_q == PASS);
  assign frame_done = frame_done_q;

`ifdef GSA_STREAM_CHECK_EN
  logic [CNT_W-1:0] pix_q, pix_d;
  logic             err_q, err_d;

  always_comb begin
    pix_d = pix_q;
    err_d = err_q;
    if (start) begin
      pix_d = '0;
    end else if (hs) begin
      if (sel_tlast != (pix_q == CNT_W'(H_RES - 1))) err_d = 1'b1;
      if (sel_tuser && !((pix_q == '0) && (line_q == '0))) err_d = 1'b1;
      pix_d = sel_tlast ? '0 : pix_q + 1'b1;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      pix_q <= '0;
      err_q <= 1'b0;
    end else begin
      pix_q <= pix_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_graphic_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_graphic_stream_arbiter
// Brief   : Directed self-checking bench, H_RES=4 V_RES=3 (12-beat frames).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_graphic_stream_arbiter;

  localparam int DW = 16;
  localparam int HR = 4;
  localparam int VR = 3;
  localparam int CW = 12;
  localparam int NB = HR * VR;

  logic hclk = 1'b0;
  logic hreset = 1'b1;
  logic ce = 1'b1;
  logic mode = 1'b0;
  logic fixed_sel = 1'b0;
  logic active_src, busy, frame_done, err;

  int   checks = 0;
  int   errors = 0;
  logic err_exp = 1'b0;
  logic err_bad;

  graphic_stream_arbiter_if #(.DATA_WIDTH(DW)) s0_if ();
  graphic_stream_arbiter_if #(.DATA_WIDTH(DW)) s1_if ();
  graphic_stream_arbiter_if #(.DATA_WIDTH(DW)) m_if ();

  graphic_stream_arbiter #(
    .DATA_WIDTH(DW), .H_RES(HR), .V_RES(VR), .CNT_W(CW)
  ) dut (
    .hclk(hclk), .hreset(hreset), .ce(ce), .mode(mode), .fixed_sel(fixed_sel),
    .s0(s0_if.slave), .s1(s1_if.slave), .m(m_if.master),
    .active_src(active_src), .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 hclk = ~hclk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pix(input int src, input int fr, input int k);
    return 16'(src * 4096 + fr * 256 + k);
  endfunction

  task automatic drive(input int src, input logic v, input logic [15:0] d,
                       input logic l, input logic u);
    if (src == 1) begin
      s1_if.tvalid = v; s1_if.tdata = d; s1_if.tlast = l; s1_if.tuser = u;
    end else begin
      s0_if.tvalid = v; s0_if.tdata = d; s0_if.tlast = l; s0_if.tuser = u;
    end
  endtask

  // Sends beats 0..nb-1 of a frame and checks each on the sink; when nb<NB
  // it leaves beat nb presented and returns without the end-of-frame checks.
  task automatic frame(input int src, input int fr, input int nb,
                       input bit tog, input bit bad);
    logic tl, tr, otr;
    bit   got;
    for (int k = 0; k < NB; k++) begin
      tl = (bad && k < HR) ? (k == 2) : ((k % HR) == HR - 1);
      drive(src, 1'b1, pix(src, fr, k), tl, k == 0);
      if (k == nb) return;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge hclk);
        tr = (src == 1) ? s1_if.tready : s0_if.tready;
        if (!busy) begin
          chk("idle_sof_held", tr, 1'b0);
          chk("idle_m_tvalid", m_if.tvalid, 1'b0);
        end else begin
          chk("tready_follow", tr, m_if.tready);
        end
        if (busy && tr) got = 1;
        else begin
          @(posedge hclk); #1;
          if (tog) m_if.tready = ~m_if.tready;
        end
      end
      if (!got) begin
        chk("beat_timeout", 1'b0, 1'b1);
        drive(src, 1'b0, 16'h0, 1'b0, 1'b0);
        return;
      end
      otr = (src == 1) ? s0_if.tready : s1_if.tready;
      chk("m_tvalid", m_if.tvalid, 1'b1);
      chk("m_tdata", m_if.tdata, pix(src, fr, k));
      chk("m_tuser", m_if.tuser, k == 0);
      chk("m_tlast", m_if.tlast, tl);
      chk("other_tready", otr, 1'b0);
      chk("active_src", active_src, src[0]);
      if (!bad) chk("err_beat", err, err_exp);
      @(posedge hclk); #1;
      if (tog) m_if.tready = ~m_if.tready;
    end
    drive(src, 1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge hclk);
    chk("frame_done_pulse", frame_done, 1'b1);
    chk("busy_after_frame", busy, 1'b0);
  endtask

  initial begin
`ifdef GSA_STREAM_CHECK_EN
    err_bad = 1'b1;
`else
    err_bad = 1'b0;
`endif
    drive(0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 16'h0, 1'b0, 1'b0);
    m_if.tready = 1'b1;

    // Reset values
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_active", active_src, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_m_tvalid", m_if.tvalid, 1'b0);
    @(posedge hclk); #1;
    hreset = 1'b0;

    // 1: fixed mode, source 1 only
    mode = 1'b0; fixed_sel = 1'b1;
    frame(1, 1, NB, 1'b0, 1'b0);
    @(negedge hclk);
    chk("frame_done_one_cycle", frame_done, 1'b0);

    // 2: round robin, both SOF together -> s0, s1, s0
    @(posedge hclk); #1;
    mode = 1'b1;
    drive(1, 1'b1, pix(1, 3, 0), 1'b0, 1'b1);
    frame(0, 2, NB, 1'b0, 1'b0);
    drive(0, 1'b1, pix(0, 4, 0), 1'b0, 1'b1);
    frame(1, 3, NB, 1'b0, 1'b0);
    frame(0, 4, NB, 1'b0, 1'b0);

    // 3: stray non-SOF beats flushed in IDLE, then SOF granted next cycle
    @(posedge hclk); #1;
    mode = 1'b0; fixed_sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, 16'hDEAD, 1'b0, 1'b0);
      @(negedge hclk);
      chk("flush_tready", s0_if.tready, 1'b1);
      chk("flush_m_tvalid", m_if.tvalid, 1'b0);
      @(posedge hclk); #1;
    end
    drive(0, 1'b1, pix(0, 5, 0), 1'b0, 1'b1);
    @(negedge hclk);
    chk("sof_held", s0_if.tready, 1'b0);
    chk("sof_not_busy", busy, 1'b0);
    @(posedge hclk); #1;
    chk("grant_latency", busy, 1'b1);
    frame(0, 5, NB, 1'b0, 1'b0);

    // 4: sink backpressure toggling every cycle
    frame(0, 6, NB, 1'b1, 1'b0);
    m_if.tready = 1'b1;

    // 5: reset after beat 6 aborts the frame
    @(posedge hclk); #1;
    fixed_sel = 1'b1;
    frame(1, 7, 6, 1'b0, 1'b0);
    hreset = 1'b1;
    @(negedge hclk);
    chk("rst_mid_m_tvalid", m_if.tvalid, 1'b0);
    chk("rst_mid_tready", s1_if.tready, 1'b0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    drive(1, 1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge hclk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_m_tvalid", m_if.tvalid, 1'b0);
    chk("abort_active", active_src, 1'b0);
    frame(1, 8, NB, 1'b0, 1'b0);

    // 6: early tlast in line 0
    frame(1, 9, NB, 1'b0, 1'b1);
    err_exp = err_bad;
    chk("err_after_bad", err, err_exp);
    frame(1, 10, NB, 1'b0, 1'b0);
    chk("err_sticky", err, err_exp);
    @(posedge hclk); #1;
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    err_exp = 1'b0;
    @(negedge hclk);
    chk("err_cleared", err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
